// File: rtl/bar_level_decoder.sv
// bar_level_decoder: receive-side checker for an MSB-first LED bar (thermometer) code.
// Samples bar_in, waits until the code has been stable for STABLE_CYCLES, then
// accepts it. A legal code is turned back into a fill level with a one-cycle
// level_valid strobe. Illegal codes set the sticky pattern_err flag. Accepted
// levels are also checked against the filler's +1 / wrap-to-zero sequence.
// Optional feature macro: BAR_WRAP_DETECT_EN adds the wrap pulse and the
// wrap_cnt counter ports.
module bar_level_decoder #(
  parameter int WIDTH         = 18,
  parameter int LW            = 5,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bar_in,
  output logic [LW-1:0]    level,
  output logic             level_valid,
  output logic             pattern_err,
  output logic             seq_err,
  output logic             busy
`ifdef BAR_WRAP_DETECT_EN
  ,
  output logic             wrap,
  output logic [7:0]       wrap_cnt
`endif
);

  localparam logic [0:0]       ST_WAIT  = 1'b0;
  localparam logic [0:0]       ST_HOLD  = 1'b1;
  localparam logic [7:0]       CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [LW-1:0]    FULL     = LW'(WIDTH);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] cand;
  logic [7:0]       cnt;
  logic [0:0]       state;
  logic [LW-1:0]    prev;
  logic             have_prev;

  logic [LW-1:0]    ones;
  logic             legal;
  logic             accept;
  logic             seq_bad;
  logic             wrap_hit;

  // Decode the candidate: count its ones and check it is a top-filled bar.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + {{(LW-1){1'b0}}, cand[i]};
    end
    legal = (cand == ~(ALL_ONES >> ones));
  end

  // Acceptance and sequence qualification of the decoded level.
  always_comb begin
    accept   = (s1 == cand) && (state == ST_WAIT) && (cnt == CNT_LAST);
    wrap_hit = have_prev && (prev == FULL) && (ones == '0);
    seq_bad  = have_prev && ({1'b0, ones} != ({1'b0, prev} + (LW+1)'(1))) && !wrap_hit;
  end

  assign busy = (state == ST_WAIT);

  // Input sampling, stability qualification and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= '0;
      cand        <= '0;
      cnt         <= '0;
      state       <= ST_WAIT;
      level       <= '0;
      level_valid <= 1'b0;
      pattern_err <= 1'b0;
      seq_err     <= 1'b0;
      have_prev   <= 1'b0;
      prev        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      s1          <= bar_in;
      level_valid <= 1'b0;
      seq_err     <= 1'b0;
      if (s1 != cand) begin
        cand  <= s1;
        cnt   <= '0;
        state <= ST_WAIT;
      end else if (state == ST_WAIT) begin
        if (cnt == CNT_LAST) begin
          state <= ST_HOLD;
          if (legal) begin
            level       <= ones;
            level_valid <= 1'b1;
            pattern_err <= 1'b0;
            seq_err     <= seq_bad;
            have_prev   <= 1'b1;
            prev        <= ones;
          end else begin
            pattern_err <= 1'b1;
          end
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

`ifdef BAR_WRAP_DETECT_EN
  // Wrap detection: pulse on a legal WIDTH -> 0 accept and count those pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap     <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      wrap <= accept && legal && wrap_hit;
      if (accept && legal && wrap_hit) begin
        wrap_cnt <= wrap_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bar_level_decoder.sv
// Testbench for bar_level_decoder: directed steps followed by random bar codes,
// checked against a run-length behavioural model of the decoder.
module tb_bar_level_decoder;

  localparam int WIDTH = 18;
  localparam int LW    = 5;
  localparam int SC    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] bar_in;
  logic [LW-1:0]    level;
  logic             level_valid;
  logic             pattern_err;
  logic             seq_err;
  logic             busy;
`ifdef BAR_WRAP_DETECT_EN
  logic             wrap;
  logic [7:0]       wrap_cnt;
`endif

  bar_level_decoder #(.WIDTH(WIDTH), .LW(LW), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bar_in      (bar_in),
    .level       (level),
    .level_valid (level_valid),
    .pattern_err (pattern_err),
    .seq_err     (seq_err),
    .busy        (busy)
`ifdef BAR_WRAP_DETECT_EN
    ,
    .wrap        (wrap),
    .wrap_cnt    (wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a code is accepted once the sampler has seen it on
  // SC+1 consecutive edges; the accept happens on the following edge.
  logic [WIDTH-1:0] run_val;
  int               run_len;
  int               m_level, m_prev, m_wrapcnt;
  bit               m_valid, m_perr, m_seq, m_busy, m_have, m_wrap;

  function automatic logic [WIDTH-1:0] code_of(input int n);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int b = 0; b < n; b++) c[WIDTH-1-b] = 1'b1;
    return c;
  endfunction

  function automatic int legal_level(input logic [WIDTH-1:0] code);
    for (int n = 0; n <= WIDTH; n++) begin
      if (code_of(n) == code) return n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    run_val   = '0;
    run_len   = 2;   // reset leaves sampler and candidate both holding zero
    m_level   = 0;
    m_prev    = 0;
    m_wrapcnt = 0;
    m_valid   = 0;
    m_perr    = 0;
    m_seq     = 0;
    m_wrap    = 0;
    m_busy    = 1;
    m_have    = 0;
  endtask

  task automatic model_edge(input logic [WIDTH-1:0] x);
    int n;
    m_valid = 0;
    m_seq   = 0;
    m_wrap  = 0;
    if (run_len == SC + 1) begin
      n = legal_level(run_val);
      if (n < 0) begin
        m_perr = 1;
      end else begin
        m_valid = 1;
        m_perr  = 0;
        if (m_have && m_prev == WIDTH && n == 0) begin
          m_wrap    = 1;
          m_wrapcnt = (m_wrapcnt + 1) % 256;
        end else if (m_have && n != m_prev + 1) begin
          m_seq = 1;
        end
        m_level = n;
        m_prev  = n;
        m_have  = 1;
      end
    end
    m_busy = (run_len < SC + 1);
    if (x == run_val) begin
      if (run_len < 255) run_len++;
    end else begin
      run_val = x;
      run_len = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("level",       32'(level),       32'(m_level));
    chk("level_valid", 32'(level_valid), 32'(m_valid));
    chk("pattern_err", 32'(pattern_err), 32'(m_perr));
    chk("seq_err",     32'(seq_err),     32'(m_seq));
    chk("busy",        32'(busy),        32'(m_busy));
`ifdef BAR_WRAP_DETECT_EN
    chk("wrap",        32'(wrap),        32'(m_wrap));
    chk("wrap_cnt",    32'(wrap_cnt),    32'(m_wrapcnt));
`endif
  endtask

  // One clock: drive v, let the edge happen, update the model, check 1 ns later.
  task automatic step(input logic [WIDTH-1:0] v);
    bar_in = v;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(v);
    #1;
    check_all();
  endtask

  task automatic hold(input logic [WIDTH-1:0] v, input int cycles);
    for (int i = 0; i < cycles; i++) step(v);
  endtask

  initial begin
    int next_lvl;
    int mode;
    logic [WIDTH-1:0] v;

    rst    = 1'b1;
    bar_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Zero after reset release qualifies on the 4th edge.
    hold(18'h00000, 6);
    chk("lvl_after_zero", 32'(level), 32'd0);

    // Level 4, then 5 in sequence, then back to 4 (a sequence error).
    hold(18'h3C000, 7);
    chk("lvl4", 32'(level), 32'd4);
    chk("busy_hold", 32'(busy), 32'd0);
    hold(18'h3E000, 7);
    chk("lvl5", 32'(level), 32'd5);
    hold(18'h3C000, 7);

    // Two-cycle glitch must not be accepted.
    hold(18'h3E000, 2);
    hold(18'h3C000, 3);
    chk("glitch_lvl", 32'(level), 32'd4);
    hold(18'h3C000, 4);

    // Illegal code, then a legal one clears pattern_err.
    hold(18'h2A000, 7);
    chk("perr_set", 32'(pattern_err), 32'd1);
    chk("perr_lvl", 32'(level), 32'd4);
    hold(18'h3F000, 7);
    chk("lvl6", 32'(level), 32'd6);

    // 17, 18, wrap to 0, then 0 -> 2 out of sequence.
    hold(18'h3FFFE, 6);
    hold(18'h3FFFF, 6);
    hold(18'h00000, 6);
    hold(18'h30000, 6);
    chk("lvl2", 32'(level), 32'd2);

    // Reset two cycles into qualification: immediate clear, no pulse.
    hold(18'h3C000, 2);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    hold(18'h3C000, 2);
    rst = 1'b0;
    hold(18'h3C000, 8);
    chk("lvl_after_rst", 32'(level), 32'd4);

    // Random codes: mostly the filler's sequence, some jumps and raw junk.
    next_lvl = 5;
    for (int it = 0; it < 600; it++) begin
      mode = $urandom_range(0, 99);
      if (mode < 70) begin
        v        = code_of(next_lvl);
        next_lvl = (next_lvl == WIDTH) ? 0 : next_lvl + 1;
      end else if (mode < 85) begin
        v = code_of($urandom_range(0, WIDTH));
      end else begin
        v = WIDTH'($urandom);
      end
      hold(v, $urandom_range(1, 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
